sa_result_collector: RTL and testbench
======================================

SA_RESULT_COLLECTOR -- requirements
Module: sa_result_collector

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of one column result word.
REQ-002 Parameter COLS, default 4, number of systolic columns drained.
REQ-003 Parameter DEPTH, default 8, per-column deskew FIFO depth; power of 2 and greater than COLS.
REQ-004 Parameter CNT_WIDTH, default 8, width of vector counters.
REQ-005 One clock; reset is asynchronous and active-high.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 start  input  1  one-cycle pulse beginning a collection job.
REQ-009 num_vec  input  CNT_WIDTH  result vectors expected in the job, sampled on start.
REQ-010 col_data  input  COLS*DATA_WIDTH  bottom-row PE vertical outputs; column c in bits [c*DATA_WIDTH +: DATA_WIDTH].
REQ-011 col_valid  input  COLS  per-column qualifier for col_data (skewed in time by column).
REQ-012 stall  output  1  request to the array controller to freeze compute/shift-out.
REQ-013 out_data  output  COLS*DATA_WIDTH  deskewed result vector, same lane packing as col_data.
REQ-014 out_valid  output  1  out_data holds a complete vector.
REQ-015 out_ready  input  1  downstream accepts out_data.
REQ-016 busy  output  1  job in progress.
REQ-017 done  output  1  one-cycle pulse at job completion.
REQ-018 overflow_err  output  1  sticky error flag.

Function
REQ-019 State machine IDLE, COLLECT, DONE; reset state IDLE.
REQ-020 IDLE: start with num_vec != 0 -> COLLECT, clearing all FIFOs, counters and overflow_err; start with num_vec == 0 -> DONE; col_valid ignored.
REQ-021 COLLECT: start ignored; busy = 1.
REQ-022 COLLECT: lane c pushes col_data lane c into FIFO c when col_valid[c] = 1, FIFO c has room, and lane accept count < num_vec.
REQ-023 Push to a full FIFO permitted only when that FIFO pops in the same cycle; otherwise word dropped and overflow_err set.
REQ-024 Lane push beyond num_vec accepted words: word dropped, overflow_err set.
REQ-025 out_valid = 1 iff state COLLECT and every FIFO non-empty; out_data = FIFO heads; combinational from registered FIFO state.
REQ-026 Word pushed in cycle t visible at out_data no earlier than cycle t+1.
REQ-027 Pop all FIFOs simultaneously on out_valid && out_ready; out_data stable while out_valid && !out_ready.
REQ-028 Emitted-vector counter increments per pop; pop bringing count to num_vec -> DONE.
REQ-029 DONE: done = 1 for exactly one cycle, then IDLE; busy = 0.
REQ-030 stall = 1 when any FIFO occupancy >= DEPTH - COLS, else 0; combinational from occupancy.
REQ-031 Per-FIFO pointers wrap modulo DEPTH; occupancy 0..DEPTH with distinct full/empty.
REQ-032 overflow_err holds until rst or next accepted start.

Reset
REQ-033 On rst: state IDLE, FIFOs empty, all counters 0, out_data 0, out_valid 0, stall 0, busy 0, done 0, overflow_err 0.
REQ-034 rst asserted mid-job aborts the job; no done pulse; outputs reach reset values asynchronously.

Verification
REQ-035 Skewed drain: num_vec=3, lane c valid cycles 2+c..4+c, data 16*c+k -> out_valid first in cycle 6; vectors {0,16,32,48},{1,17,33,49},{2,18,34,50}; done pulse after third pop.
REQ-036 Backpressure: out_ready=0 while 5 vectors arrive -> stall=1 once any occupancy >= 4, out_data held at vector 0; release -> 5 vectors in order, no loss, overflow_err=0.
REQ-037 Overflow: out_ready=0, 9 pushes on lane 0 -> ninth dropped, overflow_err=1 and stays 1 until next start.
REQ-038 Full with simultaneous pop: lane 0 full, out_ready=1 and push same cycle -> push accepted, occupancy stays 8, overflow_err=0.
REQ-039 Excess/zero/start: num_vec=0 start -> done next cycle, busy never 1; num_vec=2 with 3 lane-1 pushes -> overflow_err=1, exactly 2 vectors out; start during COLLECT ignored.
REQ-040 Reset mid-job: rst after 1 of 4 vectors -> all outputs 0 same cycle, no done; subsequent start num_vec=1 completes normally.

Source files
------------

// File: rtl/sa_result_collector.sv
// Systolic-array result collector: per-column deskew FIFOs that realign skewed
// bottom-row outputs into whole result vectors, with backpressure and a job FSM.
`timescale 1ns/1ps
module sa_result_collector #(
  parameter int DATA_WIDTH = 8,
  parameter int COLS       = 4,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [CNT_WIDTH-1:0]       num_vec,
  input  logic [COLS*DATA_WIDTH-1:0] col_data,
  input  logic [COLS-1:0]            col_valid,
  output logic                       stall,
  output logic [COLS*DATA_WIDTH-1:0] out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       done,
  output logic                       overflow_err,
  output logic [1:0]                 dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] STALL_LVL = (AW+1)'(DEPTH - COLS);
  localparam logic [AW:0] FULL_LVL  = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q [COLS][DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [COLS][DEPTH];
  logic [AW-1:0]         wr_ptr_q [COLS];
  logic [AW-1:0]         wr_ptr_d [COLS];
  logic [AW-1:0]         rd_ptr_q [COLS];
  logic [AW-1:0]         rd_ptr_d [COLS];
  logic [AW:0]           occ_q [COLS];
  logic [AW:0]           occ_d [COLS];
  logic [CNT_WIDTH-1:0]  acc_cnt_q [COLS];
  logic [CNT_WIDTH-1:0]  acc_cnt_d [COLS];
  logic [CNT_WIDTH-1:0]  vec_cnt_q, vec_cnt_d;
  logic [CNT_WIDTH-1:0]  num_vec_q, num_vec_d;
  logic                  err_q, err_d;
  logic                  lane_push [COLS];
  logic                  all_ne;
  logic                  pop;

  // Output handshake: a vector is offered (out_valid) only when every lane has a
  // word; it transfers on a cycle where out_valid && out_ready, and out_data is
  // held unchanged for as long as out_valid is high and out_ready is low.
  always_comb begin
    all_ne   = 1'b1;
    stall    = 1'b0;
    out_data = '0;
    for (int c = 0; c < COLS; c++) begin
      if (occ_q[c] == '0) all_ne = 1'b0;
      if (occ_q[c] >= STALL_LVL) stall = 1'b1;
    end
    out_valid = (state_q == ST_COLLECT) && all_ne;
    for (int c = 0; c < COLS; c++) begin
      out_data[c*DATA_WIDTH +: DATA_WIDTH] = out_valid ? mem_q[c][rd_ptr_q[c]] : '0;
    end
    pop = out_valid && out_ready;
  end

  assign busy         = (state_q == ST_COLLECT);
  assign done         = (state_q == ST_DONE);
  assign overflow_err = err_q;
  assign dbg_state    = state_q;

  always_comb begin
    state_d   = state_q;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    occ_d     = occ_q;
    acc_cnt_d = acc_cnt_q;
    vec_cnt_d = vec_cnt_q;
    num_vec_d = num_vec_q;
    err_d     = err_q;
    for (int c = 0; c < COLS; c++) lane_push[c] = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          err_d = 1'b0;
          if (num_vec != '0) begin
            state_d   = ST_COLLECT;
            num_vec_d = num_vec;
            vec_cnt_d = '0;
            for (int c = 0; c < COLS; c++) begin
              wr_ptr_d[c]  = '0;
              rd_ptr_d[c]  = '0;
              occ_d[c]     = '0;
              acc_cnt_d[c] = '0;
            end
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_COLLECT: begin
        for (int c = 0; c < COLS; c++) begin
          if (col_valid[c]) begin
            // A full lane may still take a word when the same cycle pops it.
            if (acc_cnt_q[c] == num_vec_q) begin
              err_d = 1'b1;
            end else if ((occ_q[c] == FULL_LVL) && !pop) begin
              err_d = 1'b1;
            end else begin
              lane_push[c]               = 1'b1;
              mem_d[c][wr_ptr_q[c]]      = col_data[c*DATA_WIDTH +: DATA_WIDTH];
              wr_ptr_d[c]                = wr_ptr_q[c] + 1'b1;
              acc_cnt_d[c]               = acc_cnt_q[c] + 1'b1;
            end
          end
          occ_d[c] = occ_q[c] + (AW+1)'(lane_push[c]) - (AW+1)'(pop);
          if (pop) rd_ptr_d[c] = rd_ptr_q[c] + 1'b1;
        end
        if (pop) begin
          vec_cnt_d = vec_cnt_q + 1'b1;
          if (vec_cnt_d == num_vec_q) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      vec_cnt_q <= '0;
      num_vec_q <= '0;
      err_q     <= 1'b0;
      for (int c = 0; c < COLS; c++) begin
        wr_ptr_q[c]  <= '0;
        rd_ptr_q[c]  <= '0;
        occ_q[c]     <= '0;
        acc_cnt_q[c] <= '0;
        for (int i = 0; i < DEPTH; i++) mem_q[c][i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      acc_cnt_q <= acc_cnt_d;
      vec_cnt_q <= vec_cnt_d;
      num_vec_q <= num_vec_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_sa_result_collector.sv
// Bench for sa_result_collector: directed scenarios plus random jobs, checked
// by a queue-based job model and an expected-vector scoreboard.
`timescale 1ns/1ps
module tb_sa_result_collector;

  localparam int DW    = 8;
  localparam int COLS  = 4;
  localparam int DEPTH = 8;
  localparam int CW    = 8;
  localparam int W     = COLS*DW;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] num_vec;
  logic [W-1:0]  col_data;
  logic [COLS-1:0] col_valid;
  logic          stall;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;
  logic          overflow_err;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  sa_result_collector #(
    .DATA_WIDTH(DW), .COLS(COLS), .DEPTH(DEPTH), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_vec(num_vec),
    .col_data(col_data), .col_valid(col_valid), .stall(stall),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .overflow_err(overflow_err), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard / model state ----------------
  int checks = 0;
  int failures = 0;
  int pops_total = 0;
  logic [W-1:0]  exp_q[$];
  logic [DW-1:0] lane_q [COLS][$];
  int m_state;            // 0 idle, 1 collecting, 2 done pulse
  int m_nv;
  int m_emit;
  int m_acc [COLS];
  int m_occ [COLS];
  bit m_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_nv = 0; m_emit = 0; m_err = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      m_acc[c] = 0; m_occ[c] = 0; lane_q[c].delete();
    end
    exp_q.delete();
  endtask

  // One clock of job behaviour, evaluated from the inputs presented this cycle.
  task automatic model_step();
    bit pop;
    bit all;
    logic [W-1:0] vec;
    pop = (m_state == 1) && (out_ready == 1'b1);
    for (int c = 0; c < COLS; c++) if (m_occ[c] == 0) pop = 1'b0;
    case (m_state)
      0: if (start) begin
        m_err = 1'b0;
        if (num_vec != 0) begin
          model_reset();
          m_state = 1;
          m_nv = int'(num_vec);
        end else begin
          m_state = 2;
        end
      end
      1: begin
        for (int c = 0; c < COLS; c++) begin
          if (col_valid[c]) begin
            if (m_acc[c] >= m_nv) m_err = 1'b1;
            else if (m_occ[c] == DEPTH && !pop) m_err = 1'b1;
            else begin
              lane_q[c].push_back(col_data[c*DW +: DW]);
              m_acc[c]++;
              m_occ[c]++;
            end
          end
        end
        if (pop) begin
          for (int c = 0; c < COLS; c++) m_occ[c]--;
          m_emit++;
          if (m_emit == m_nv) m_state = 2;
        end
      end
      default: m_state = 0;
    endcase
    all = 1'b1;
    for (int c = 0; c < COLS; c++) if (lane_q[c].size() == 0) all = 1'b0;
    while (all) begin
      for (int c = 0; c < COLS; c++) vec[c*DW +: DW] = lane_q[c].pop_front();
      exp_q.push_back(vec);
      for (int c = 0; c < COLS; c++) if (lane_q[c].size() == 0) all = 1'b0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    if (!rst) model_step();
  end

  // ---------------- monitor ----------------
  initial forever begin
    bit exp_ov;
    bit exp_stall;
    @(negedge clk);
    if (rst) begin
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_stall", 64'(stall), 64'd0);
      chk("rst_overflow_err", 64'(overflow_err), 64'd0);
    end else begin
      exp_ov = (m_state == 1);
      exp_stall = 1'b0;
      for (int c = 0; c < COLS; c++) begin
        if (m_occ[c] == 0) exp_ov = 1'b0;
        if (m_occ[c] >= DEPTH - COLS) exp_stall = 1'b1;
      end
      chk("out_valid", 64'(out_valid), 64'(exp_ov));
      chk("stall", 64'(stall), 64'(exp_stall));
      chk("busy", 64'(busy), 64'(m_state == 1));
      chk("done", 64'(done), 64'(m_state == 2));
      chk("overflow_err", 64'(overflow_err), 64'(m_err));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL out_data actual=%0h expected=none", out_data);
        end else begin
          chk("out_data", 64'(out_data), 64'(exp_q[0]));
          if (out_ready) begin
            void'(exp_q.pop_front());
            pops_total++;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic st, input logic [CW-1:0] nv, input logic [COLS-1:0] v,
                      input logic [W-1:0] d, input logic rdy);
    start = st; num_vec = nv; col_valid = v; col_data = d; out_ready = rdy;
    @(posedge clk); #1;
    start = 1'b0; col_valid = '0;
  endtask

  task automatic finish_job(input bit excess);
    logic [COLS-1:0] v;
    int n;
    n = 0;
    while (m_state != 0 && n < 3000) begin
      for (int c = 0; c < COLS; c++) begin
        if (m_acc[c] < m_nv) v[c] = 1'($urandom_range(0, 1));
        else v[c] = excess && ($urandom_range(0, 15) == 0);
      end
      step(1'b0, '0, v, W'($urandom), $urandom_range(0, 3) != 0);
      n++;
    end
    step(1'b0, '0, '0, '0, 1'b1);
    chk("job_complete_busy", 64'(busy), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int first;
    int p0;
    logic [COLS-1:0] v;
    logic [W-1:0] d;
    rst = 1'b1; start = 1'b0; num_vec = '0; col_data = '0; col_valid = '0; out_ready = 1'b0;
    model_reset();
    #12;
    chk("reset_dbg_state", 64'(dbg_state), 64'd0);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    step(1'b0, '0, '0, '0, 1'b0);

    // skewed drain, three vectors
    first = -1;
    p0 = pops_total;
    for (int r = 0; r < 12; r++) begin
      v = '0; d = '0;
      for (int c = 0; c < COLS; c++) begin
        if (r >= 2 + c && r <= 4 + c) begin
          v[c] = 1'b1;
          d[c*DW +: DW] = DW'(16*c + r - 2 - c);
        end
      end
      start = (r == 0); num_vec = 8'd3; col_valid = v; col_data = d; out_ready = 1'b1;
      #3;
      if (out_valid && first < 0) first = r;
      if (r == 6) chk("skew_vec0", 64'(out_data), 64'h30201000);
      if (r == 7) chk("skew_vec1", 64'(out_data), 64'h31211101);
      if (r == 8) chk("skew_vec2", 64'(out_data), 64'h32221202);
      if (r == 9) chk("skew_done", 64'(done), 64'd1);
      @(posedge clk); #1;
    end
    start = 1'b0; col_valid = '0;
    chk("skew_first_valid_cycle", 64'(first), 64'd6);
    chk("skew_vector_count", 64'(pops_total - p0), 64'd3);

    // backpressure: five vectors arrive while downstream is blocked
    p0 = pops_total;
    step(1'b1, 8'd5, '0, '0, 1'b0);
    for (int k = 0; k < 5; k++) step(1'b0, '0, 4'b1111, W'($urandom), 1'b0);
    #3;
    chk("bp_stall", 64'(stall), 64'd1);
    for (int k = 0; k < 8; k++) step(1'b0, '0, '0, '0, 1'b1);
    chk("bp_vector_count", 64'(pops_total - p0), 64'd5);
    chk("bp_overflow_err", 64'(overflow_err), 64'd0);

    // overflow: nine pushes into lane 0 with no pops
    step(1'b1, 8'd20, '0, '0, 1'b0);
    for (int k = 0; k < 9; k++) step(1'b0, '0, 4'b0001, W'($urandom), 1'b0);
    #3;
    chk("ovf_err_set", 64'(overflow_err), 64'd1);
    finish_job(1'b0);
    chk("ovf_err_sticky", 64'(overflow_err), 64'd1);

    // full lane accepts a push when the same cycle pops
    step(1'b1, 8'd20, '0, '0, 1'b0);
    #3;
    chk("start_clears_err", 64'(overflow_err), 64'd0);
    for (int k = 0; k < DEPTH; k++) step(1'b0, '0, 4'b1111, W'($urandom), 1'b0);
    step(1'b0, '0, 4'b0001, W'($urandom), 1'b1);
    #3;
    chk("full_pop_push_err", 64'(overflow_err), 64'd0);
    chk("full_pop_push_stall", 64'(stall), 64'd1);
    finish_job(1'b0);

    // zero-length job
    step(1'b1, 8'd0, '0, '0, 1'b1);
    #3;
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_busy", 64'(busy), 64'd0);
    step(1'b0, '0, '0, '0, 1'b1);
    #3;
    chk("zero_done_once", 64'(done), 64'd0);

    // excess words on lane 1, start ignored mid-job
    p0 = pops_total;
    step(1'b1, 8'd2, '0, '0, 1'b1);
    step(1'b0, '0, 4'b1111, W'($urandom), 1'b1);
    step(1'b1, 8'd7, 4'b1111, W'($urandom), 1'b1);
    step(1'b0, '0, 4'b0010, W'($urandom), 1'b1);
    finish_job(1'b0);
    chk("excess_err", 64'(overflow_err), 64'd1);
    chk("excess_vector_count", 64'(pops_total - p0), 64'd2);

    // reset in the middle of a job
    step(1'b1, 8'd4, '0, '0, 1'b1);
    step(1'b0, '0, 4'b1111, W'($urandom), 1'b1);
    step(1'b0, '0, '0, '0, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_out_data", 64'(out_data), 64'd0);
    chk("midrst_stall", 64'(stall), 64'd0);
    chk("midrst_overflow_err", 64'(overflow_err), 64'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    p0 = pops_total;
    step(1'b1, 8'd1, '0, '0, 1'b1);
    finish_job(1'b0);
    chk("post_rst_vector_count", 64'(pops_total - p0), 64'd1);

    // random jobs
    for (int j = 0; j < 8; j++) begin
      step(1'b1, CW'($urandom_range(1, 12)), '0, '0, 1'b1);
      finish_job(j[0]);
    end

    step(1'b0, '0, '0, '0, 1'b1);
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
